// File: rtl/collatz_if.sv
// Handshake and result bundle between a sequencer and the Collatz engine.
// The master drives enable, start and seed; the slave reports status and results.
interface collatz_if #(
    parameter int W = 14,
    parameter int C = 8
);
    logic         en;
    logic         start;
    logic [W-1:0] seed;
    logic         busy;
    logic         done;
    logic [W-1:0] value;
    logic [C-1:0] steps;
    logic [W-1:0] peak;
    logic         ovf;
    logic         err;
    logic         step_sat;

    modport master (
        output en, start, seed,
        input  busy, done, value, steps, peak, ovf, err, step_sat
    );

    modport slave (
        input  en, start, seed,
        output busy, done, value, steps, peak, ovf, err, step_sat
    );
endinterface

// File: rtl/collatz_engine.sv
// Steps a Collatz sequence from a seed, one step per enabled cycle, and tracks the
// step count, the peak value and the overflow, zero-seed and counter-saturation flags.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// RUN    | stepping the sequence on cycles with en=1
// DONE   | finished (reached 1, overflow or zero seed); results held
module collatz_engine #(
    parameter int W        = 14,
    parameter int C        = 8,
    parameter int SHORTCUT = 0
) (
    input logic      clk,
    input logic      arst,
    collatz_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [C-1:0] STEPS_MAX = '1;

    state_t       state_q, state_d;
    logic [W-1:0] value_q, value_d;
    logic [C-1:0] steps_q, steps_d;
    logic [W-1:0] peak_q, peak_d;
    logic         ovf_q, ovf_d;
    logic         err_q, err_d;
    logic         step_sat_q, step_sat_d;

    logic [W+1:0] odd_full;
    logic [W+1:0] odd_next;
    logic         odd_fits;
    logic [C-1:0] steps_inc;

    // 3n+1 built as n + 2n + 1 in W+2 bits so the largest odd value cannot wrap
    assign odd_full  = {2'b00, value_q} + {1'b0, value_q, 1'b0} + (W+2)'(1);
    assign odd_next  = (SHORTCUT != 0) ? (odd_full >> 1) : odd_full;
    assign odd_fits  = (odd_next[W+1:W] == 2'b00);
    assign steps_inc = (steps_q == STEPS_MAX) ? steps_q : steps_q + C'(1);

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        steps_d    = steps_q;
        peak_d     = peak_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        step_sat_d = step_sat_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    steps_d    = '0;
                    ovf_d      = 1'b0;
                    step_sat_d = 1'b0;
                    if (bus.seed != '0) begin
                        state_d = S_RUN;
                        value_d = bus.seed;
                        peak_d  = bus.seed;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        value_d = '0;
                        peak_d  = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.en) begin
                    if (value_q == W'(1)) begin
                        state_d = S_DONE;
                    end else if (!value_q[0]) begin
                        value_d    = value_q >> 1;
                        steps_d    = steps_inc;
                        step_sat_d = step_sat_q | (steps_inc == STEPS_MAX);
                    end else if (odd_fits) begin
                        value_d    = odd_next[W-1:0];
                        steps_d    = steps_inc;
                        step_sat_d = step_sat_q | (steps_inc == STEPS_MAX);
                        if (odd_next[W-1:0] > peak_q) begin
                            peak_d = odd_next[W-1:0];
                        end
                    end else begin
                        state_d = S_DONE;
                        ovf_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q    <= S_IDLE;
            value_q    <= '0;
            steps_q    <= '0;
            peak_q     <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            step_sat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            steps_q    <= steps_d;
            peak_q     <= peak_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            step_sat_q <= step_sat_d;
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.value    = value_q;
    assign bus.steps    = steps_q;
    assign bus.peak     = peak_q;
    assign bus.ovf      = ovf_q;
    assign bus.err      = err_q;
    assign bus.step_sat = step_sat_q;
endmodule

// File: doc/collatz_engine.md
COLLATZ_ENGINE -- requirements
Module: collatz_engine

Interface
REQ-001 Parameter W, default 14: width of the sequence value, seed and peak.
REQ-002 Parameter C, default 8: width of the step counter.
REQ-003 Parameter SHORTCUT, default 0: 0 maps odd n to 3n+1; 1 maps odd n to (3n+1)/2 in a single step.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 arst  input  1  reset, synchronous and active-high; the name is kept for codebase consistency.
REQ-006 en  input  1  step enable, e.g. a one-second tick; RUN advances only on cycles with en=1.
REQ-007 start  input  1  single-cycle request to begin a new sequence from seed.
REQ-008 seed  input  W  starting value, sampled on the accepted start cycle.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  high while in DONE.
REQ-011 value  output  W  current sequence value.
REQ-012 steps  output  C  number of steps taken since start.
REQ-013 peak  output  W  largest value reached since start, seed included.
REQ-014 ovf  output  1  sequence halted because the next value would not fit in W bits.
REQ-015 err  output  1  sequence rejected because seed = 0.
REQ-016 step_sat  output  1  steps has saturated at 2^C-1.

Function
REQ-017 The block shall use three states, IDLE, RUN and DONE, encoded internally; busy and done shall be decoded from the state.
REQ-018 In IDLE or DONE, start=1 with seed>=1 shall move to RUN at the next edge, loading value=seed, peak=seed, steps=0 and ovf=err=step_sat=0, regardless of en.
REQ-019 In IDLE or DONE, start=1 with seed=0 shall move to DONE at the next edge with err=1, value=0, peak=0, steps=0 and ovf=step_sat=0.
REQ-020 In RUN, start shall be ignored.
REQ-021 In RUN with en=0, all registers shall hold.
REQ-022 In RUN with en=1 and value=1, the block shall move to DONE at the next edge; value, steps and peak shall hold.
REQ-023 In RUN with en=1 and even value>1, value shall become value>>1 and steps shall increment.
REQ-024 In RUN with en=1 and odd value>1, the next value shall be 3*value+1, or (3*value+1)>>1 when SHORTCUT=1.
REQ-025 The odd-value next value shall be computed in W+2 bits.
REQ-026 If the odd-value result fits in W bits, value shall load it, steps shall increment and peak shall update if the result exceeds peak.
REQ-027 If the odd-value result exceeds 2^W-1, the block shall move to DONE with ovf=1; value, steps and peak shall hold their pre-step values.
REQ-028 The steps counter shall saturate at 2^C-1 and set step_sat=1; the sequence shall continue running with steps frozen.
REQ-029 A seed of 1 shall complete with steps=0 and peak=1 on the first en cycle in RUN.
REQ-030 In DONE, all outputs shall hold until the next accepted start or reset.
REQ-031 If start and en are both high in IDLE or DONE, start shall take effect; no step shall occur on that cycle.

Reset
REQ-032 arst=1 at a clock edge shall force IDLE and clear value, steps, peak, ovf, err and step_sat, from any state including mid-RUN.
REQ-033 arst shall have priority over start and en.
REQ-034 After reset, busy=0 and done=0.

Verification
REQ-035 W=14, SHORTCUT=0, seed=6 -> sequence 6,3,10,5,16,8,4,2,1; done after 9 en cycles in RUN; steps=8, peak=16, ovf=0.
REQ-036 W=14, SHORTCUT=0, seed=27 -> done with steps=111, peak=9232, value=1, ovf=0.
REQ-037 SHORTCUT=1, seed=6 -> sequence 6,3,5,8,4,2,1; steps=6, peak=8.
REQ-038 W=8, seed=27 -> ovf=1, done=1, value=107, steps=11, peak=214.
REQ-039 seed=0 -> done=1, err=1, steps=0 at the edge after start; then start with seed=6 -> busy=1 and err=0 at the next edge.
REQ-040 C=4, W=14, seed=27 -> step_sat=1 and steps=15 until completion, peak=9232; arst asserted mid-RUN -> IDLE and all outputs 0 at the next edge.
